// File: rtl/cim_host_sequencer.sv
// rtl/cim_host_sequencer.sv - host-side command sequencer for the CIM macro controller
// Issues one read/write/CIM op at a time, serialises the operand and holds the response.
module cim_host_sequencer #(
  parameter int INPUT_BIT_WIDTH = 8,
  parameter int ADDR_WIDTH      = 6,
  parameter int DATA_WIDTH      = 8,
  parameter int OUT_WIDTH       = 16,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr,
  input  logic [DATA_WIDTH-1:0]      cmd_wdata,
  input  logic [INPUT_BIT_WIDTH-1:0] cmd_operand,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [OUT_WIDTH-1:0]       rsp_data,
  output logic                       rsp_err,
  output logic [1:0]                 ctrl_r_w_cim,
  output logic                       ctrl_start,
  input  logic                       ctrl_busy,
  input  logic                       ctrl_rd_data_enable,
  input  logic                       ctrl_cim_data_enable,
  input  logic                       ctrl_in_msb,
  output logic [ADDR_WIDTH-1:0]      macro_addr,
  output logic [DATA_WIDTH-1:0]      macro_wdata,
  output logic                       cim_in_bit,
  input  logic [DATA_WIDTH-1:0]      macro_rd_data,
  input  logic [OUT_WIDTH-1:0]       macro_cim_data
);

  localparam int WD_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SH_W       = $clog2(INPUT_BIT_WIDTH + 1);
  localparam int WAIT_LIMIT = 4;

  localparam logic [1:0] OP_ILLEGAL = 2'b00;
  localparam logic [1:0] OP_READ    = 2'b01;
  localparam logic [1:0] OP_CIM     = 2'b11;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, RUN, RESP} state_t;

  state_t                     state, state_nxt;
  logic                       err_nxt;
  logic [1:0]                 op_q;
  logic [INPUT_BIT_WIDTH-1:0] shreg;
  logic [SH_W-1:0]            sh_cnt;
  logic                       sh_active;
  logic [WD_W-1:0]            wd_cnt;
  logic                       accept, active, enter_resp, shift_en;

  assign accept     = (state == IDLE) && cmd_valid && cmd_ready;
  assign active     = (state == WAIT_BUSY) || (state == RUN);
  assign enter_resp = (state_nxt == RESP) && (state != RESP);
  // Shifting starts on the first in_msb slot and then free-runs for the remaining bits.
  assign shift_en   = active && (op_q == OP_CIM) && (sh_active || ctrl_in_msb) &&
                      (sh_cnt < SH_W'(INPUT_BIT_WIDTH - 1));

  assign ctrl_start = (state == ISSUE);
  assign rsp_valid  = (state == RESP);
  assign cim_in_bit = shreg[INPUT_BIT_WIDTH-1];

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_op == OP_ILLEGAL) begin
            state_nxt = RESP;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (ctrl_busy) begin
          state_nxt = RUN;
        end else if (wd_cnt == WD_W'(WAIT_LIMIT - 1)) begin
          state_nxt = RESP;
          err_nxt   = 1'b1;
        end
      end
      RUN: begin
        // Busy falling beats a watchdog expiry on the same edge.
        if (!ctrl_busy) begin
          state_nxt = RESP;
        end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = RESP;
          err_nxt   = 1'b1;
        end
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cmd_ready    <= 1'b0;
      op_q         <= 2'b00;
      ctrl_r_w_cim <= 2'b00;
      macro_addr   <= '0;
      macro_wdata  <= '0;
      shreg        <= '0;
      sh_cnt       <= '0;
      sh_active    <= 1'b0;
      wd_cnt       <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == IDLE);

      if (accept) begin
        op_q         <= cmd_op;
        ctrl_r_w_cim <= cmd_op;
        macro_addr   <= cmd_addr;
        macro_wdata  <= cmd_wdata;
        shreg        <= cmd_operand;
        sh_cnt       <= '0;
        sh_active    <= 1'b0;
        rsp_data     <= '0;
        rsp_err      <= 1'b0;
      end

      if (state == ISSUE) begin
        wd_cnt <= '0;
      end else if (active) begin
        wd_cnt <= wd_cnt + 1'b1;
      end

      if (active) begin
        if (ctrl_rd_data_enable && (op_q == OP_READ)) begin
          rsp_data <= OUT_WIDTH'(macro_rd_data);
        end
        if (ctrl_cim_data_enable && (op_q == OP_CIM)) begin
          rsp_data <= macro_cim_data;
        end
      end

      if (shift_en) begin
        shreg     <= shreg << 1;
        sh_cnt    <= sh_cnt + 1'b1;
        sh_active <= 1'b1;
      end

      // Error responses carry no data; overrides any capture on the same edge.
      if (enter_resp) begin
        ctrl_r_w_cim <= 2'b00;
        shreg        <= '0;
        rsp_err      <= err_nxt;
        if (err_nxt) begin
          rsp_data <= '0;
        end
      end

      if ((state == RESP) && rsp_ready) begin
        rsp_data <= '0;
        rsp_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cim_host_sequencer.sv
// tb/tb_cim_host_sequencer.sv - scoreboard bench for cim_host_sequencer
// A behavioural controller model answers each op; a monitor checks every held response.
module tb_cim_host_sequencer;

  localparam int IW = 8;
  localparam int AW = 6;
  localparam int DW = 8;
  localparam int OW = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]    cmd_op, ctrl_r_w_cim;
  logic [AW-1:0] cmd_addr, macro_addr;
  logic [DW-1:0] cmd_wdata, macro_wdata, macro_rd_data;
  logic [IW-1:0] cmd_operand;
  logic [OW-1:0] rsp_data, macro_cim_data;
  logic          ctrl_start, ctrl_busy, ctrl_rd_data_enable, ctrl_cim_data_enable, ctrl_in_msb;
  logic          cim_in_bit;

  always #5 clk = ~clk;

  cim_host_sequencer #(
    .INPUT_BIT_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_operand(cmd_operand),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ctrl_r_w_cim(ctrl_r_w_cim), .ctrl_start(ctrl_start), .ctrl_busy(ctrl_busy),
    .ctrl_rd_data_enable(ctrl_rd_data_enable), .ctrl_cim_data_enable(ctrl_cim_data_enable),
    .ctrl_in_msb(ctrl_in_msb), .macro_addr(macro_addr), .macro_wdata(macro_wdata),
    .cim_in_bit(cim_in_bit), .macro_rd_data(macro_rd_data), .macro_cim_data(macro_cim_data)
  );

  typedef struct {
    logic [OW-1:0] data;
    logic          err;
    int            acc;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cycle = 0;
  int   start_cnt = 0;
  bit   hold_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {cmd_ready, rsp_valid, rsp_data, rsp_err, ctrl_r_w_cim, ctrl_start,
                 macro_addr, macro_wdata, cim_in_bit}, 64'd0);
  endtask

  always @(posedge clk) cycle <= cycle + 1;
  always @(negedge clk) if (ctrl_start) start_cnt++;

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 rsp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Response monitor: pops the scoreboard on every accepted response.
  bit            seen = 1'b0;
  logic [OW-1:0] held_data;
  logic          held_err;
  int            first_cyc;
  exp_t          e_mon;
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (!seen) begin
        seen      = 1'b1;
        held_data = rsp_data;
        held_err  = rsp_err;
        first_cyc = cycle;
        check("rsp_cmd_ready_low", cmd_ready, 0);
        check("rsp_r_w_cim_zero", ctrl_r_w_cim, 0);
      end else begin
        check("rsp_data_stable", rsp_data, held_data);
        check("rsp_err_stable", rsp_err, held_err);
      end
      if (rsp_ready) begin
        seen = 1'b0;
        if (sb.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          e_mon = sb.pop_front();
          check("rsp_data", rsp_data, e_mon.data);
          check("rsp_err", rsp_err, e_mon.err);
          check("rsp_latency", first_cyc - e_mon.acc, e_mon.lat);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input logic [IW-1:0] opnd, input logic [OW-1:0] xd, input logic xe,
                      input int xl);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_operand = opnd;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", cmd_ready, 1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    e.data = xd; e.err = xe; e.acc = cycle; e.lat = xl;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rsp_drain", sb.size(), 0);
  endtask

  // mode 0: compliant controller, 1: busy stuck high, 2: busy never rises
  task automatic run_ctrl(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [IW-1:0] opnd, input logic [DW-1:0] rd,
                          input logic [OW-1:0] cim, input int mode);
    logic [IW-1:0] bits;
    int            n = 0;
    @(negedge clk);
    check("issue_start", ctrl_start, 1);
    check("issue_r_w_cim", ctrl_r_w_cim, op);
    check("issue_msb", cim_in_bit, opnd[IW-1]);
    if (mode == 2) return;
    @(posedge clk);
    #1 ctrl_busy = 1'b1;
    if (mode == 1) begin
      while (!rsp_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      ctrl_busy = 1'b0;
      return;
    end
    @(posedge clk);
    if (op != 2'b11) begin
      // Enables for the wrong op and a stray in_msb must be ignored.
      #1 ctrl_rd_data_enable = 1'b1; macro_rd_data = rd;
      ctrl_cim_data_enable = 1'b1; macro_cim_data = 16'($urandom); ctrl_in_msb = 1'b1;
      @(negedge clk);
      check("run_macro_addr", macro_addr, addr);
      check("run_macro_wdata", macro_wdata, wd);
      check("run_r_w_cim", ctrl_r_w_cim, op);
      @(posedge clk);
      #1 ctrl_busy = 1'b0; ctrl_rd_data_enable = 1'b0; ctrl_cim_data_enable = 1'b0;
      ctrl_in_msb = 1'b0;
      @(negedge clk);
      check("noncim_no_shift", cim_in_bit, opnd[IW-1]);
    end else begin
      #1 ctrl_in_msb = 1'b1; ctrl_rd_data_enable = 1'b1; macro_rd_data = 8'($urandom);
      for (int i = 0; i < IW; i++) begin
        @(negedge clk);
        bits[IW-1-i] = cim_in_bit;
        @(posedge clk);
        #1 ctrl_in_msb = (i == 3);
        ctrl_rd_data_enable = 1'b0;
        ctrl_cim_data_enable = (i == 4) || (i == IW - 1);
        macro_cim_data = (i == IW - 1) ? cim : 16'($urandom);
      end
      @(posedge clk);
      #1 ctrl_busy = 1'b0; ctrl_cim_data_enable = 1'b0; ctrl_in_msb = 1'b0;
      check("cim_bit_stream", bits, opnd);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic [IW-1:0] opnd, input logic [DW-1:0] rd,
                       input logic [OW-1:0] cim, input int mode);
    logic [OW-1:0] xd = '0;
    logic          xe = 1'b0;
    int            xl = 4;
    int            s0 = start_cnt;
    if (op == 2'b00) begin
      xe = 1'b1; xl = 0;
    end else if (mode == 2) begin
      xe = 1'b1; xl = 5;
    end else if (mode == 1) begin
      xe = 1'b1; xl = TO + 1;
    end else if (op == 2'b01) begin
      xd = {8'h00, rd};
    end else if (op == 2'b11) begin
      xd = cim; xl = IW + 4;
    end
    send(op, addr, wd, opnd, xd, xe, xl);
    if (op != 2'b00) run_ctrl(op, addr, wd, opnd, rd, cim, mode);
    drain();
    check("start_pulses", start_cnt - s0, (op != 2'b00) ? 1 : 0);
  endtask

  initial begin
    int s0;
    int r;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = '0; cmd_operand = '0;
    ctrl_busy = 1'b0; ctrl_rd_data_enable = 1'b0; ctrl_cim_data_enable = 1'b0;
    ctrl_in_msb = 1'b0; macro_rd_data = '0; macro_cim_data = '0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset_outputs");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk) check("cmd_ready_after_reset", cmd_ready, 1);

    do_op(2'b01, 6'd5, 8'h11, 8'h6D, 8'hA5, 16'hBEEF, 0);
    do_op(2'b10, 6'd3, 8'h3C, 8'h92, 8'h77, 16'h5555, 0);
    do_op(2'b11, 6'd9, 8'h00, 8'b1011_0010, 8'h00, 16'h1234, 0);

    hold_ready = 1'b1;
    @(posedge clk);
    s0 = start_cnt;
    send(2'b00, 6'd1, 8'h44, 8'hFF, 16'h0000, 1'b1, 0);
    repeat (5) begin
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    hold_ready = 1'b0;
    drain();
    check("illegal_no_start", start_cnt - s0, 0);

    do_op(2'b11, 6'd7, 8'h00, 8'hC3, 8'h00, 16'h9999, 1);
    do_op(2'b01, 6'd2, 8'h00, 8'h00, 8'h5A, 16'h0000, 2);

    send(2'b11, 6'd33, 8'hE7, 8'hA6, 16'h0, 1'b0, IW + 4);
    @(negedge clk);
    @(posedge clk); #1 ctrl_busy = 1'b1;
    @(posedge clk); #1 ctrl_in_msb = 1'b1;
    @(posedge clk); #1 ctrl_in_msb = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1 check_outputs_zero("midop_reset_outputs");
    sb.delete();
    ctrl_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk) check("cmd_ready_after_midop_reset", cmd_ready, 1);
    do_op(2'b01, 6'd12, 8'h00, 8'h3B, 8'hC4, 16'h0000, 0);

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      do_op(2'($urandom_range(0, 3)), 6'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            16'($urandom), (r == 0) ? 1 : ((r == 1) ? 2 : 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cim_host_sequencer.md
Name: cim_host_sequencer

Overview:
- Host-side initiator for the CIM macro controller: accepts read/write/CIM commands on a valid/ready port and drives the controller's r_w_cim/start inputs.
- Follows the controller's busy, rd_data_enable, cim_data_enable and in_msb outputs.
- Serialises the CIM input operand MSB-first and captures read data or CIM results into a held response.
- Sits between the system bus adapter and the macro controller; includes a watchdog that turns a hung controller into an error response.

Parameters:
INPUT_BIT_WIDTH, 8, CIM operand bits; must match the controller's input_bit_width
ADDR_WIDTH, 6, macro row address width
DATA_WIDTH, 8, read/write data width
OUT_WIDTH, 16, CIM result width; must be >= DATA_WIDTH
TIMEOUT_CYCLES, 64, maximum cycles busy may stay high; must be > INPUT_BIT_WIDTH+2

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready at rising edge
cmd_op  in  2  01 read, 10 write, 11 CIM, 00 illegal
cmd_addr  in  ADDR_WIDTH  row address
cmd_wdata  in  DATA_WIDTH  write data
cmd_operand  in  INPUT_BIT_WIDTH  CIM input operand
rsp_valid  out  1  response held until rsp_ready
rsp_ready  in  1  response consumer ready
rsp_data  out  OUT_WIDTH  read data (zero-extended) or CIM result; 0 for write/error
rsp_err  out  1  illegal op or timeout
ctrl_r_w_cim  out  2  operation code to controller
ctrl_start  out  1  one-cycle start pulse to controller
ctrl_busy  in  1  controller busy
ctrl_rd_data_enable  in  1  read data valid
ctrl_cim_data_enable  in  1  CIM result valid
ctrl_in_msb  in  1  controller marks first input bit slot
macro_addr  out  ADDR_WIDTH  registered address, held for the whole op
macro_wdata  out  DATA_WIDTH  registered write data, held for the whole op
cim_in_bit  out  1  serial operand bit, MSB first
macro_rd_data  in  DATA_WIDTH  macro sense-amp data
macro_cim_data  in  OUT_WIDTH  macro CIM result

Behaviour:
- Reset (rst_n low, asynchronous): FSM=IDLE; all outputs 0, including cmd_ready; counters, shift register and response registers cleared. Reset mid-operation abandons the op with no response.
- States: IDLE, ISSUE, WAIT_BUSY, RUN, RESP.
- IDLE: cmd_ready=1. On accept, latch addr/wdata/operand/op; ctrl_r_w_cim<=op.
  - op=00: go directly to RESP with rsp_err=1, rsp_data=0; no ctrl_start.
  - Otherwise go to ISSUE.
- ISSUE: exactly one cycle; ctrl_start=1. Go to WAIT_BUSY.
- WAIT_BUSY: busy sampled 1 → RUN. If busy has not been seen within 4 cycles → RESP with rsp_err=1.
- RUN: busy sampled 0 → RESP. Watchdog counts cycles from entry to WAIT_BUSY; reaching TIMEOUT_CYCLES → RESP with rsp_err=1, rsp_data=0.
- Capture rules, applied in WAIT_BUSY or RUN:
  - Rising edge with ctrl_rd_data_enable=1 and op=01: rsp_data <= zero-extended macro_rd_data.
  - Rising edge with ctrl_cim_data_enable=1 and op=11: rsp_data <= macro_cim_data.
  - Last capture wins. An enable seen for the wrong op is ignored.
- RESP: rsp_valid=1; rsp_data/rsp_err stable until rsp_valid&rsp_ready at a rising edge. Then rsp_valid=0, ctrl_r_w_cim=00, → IDLE.
- cmd_ready=0 in every state except IDLE; at most one op outstanding.
- ctrl_r_w_cim held constant from ISSUE through RUN; 00 in IDLE and RESP.
- Operand serialiser:
  - Shift register loaded with cmd_operand on accept; cim_in_bit = its MSB, so the operand MSB shows from ISSUE onward.
  - First rising edge with ctrl_in_msb=1 begins shifting: shift left, zero fill, one bit per edge, exactly INPUT_BIT_WIDTH-1 shifts. The LSB is then held until RESP, which clears the register.
  - Non-CIM ops never shift.
- Latency with a compliant controller, accept at edge E0:
  - rsp_valid first high after edge E0+4 for read/write.
  - rsp_valid first high after edge E0+INPUT_BIT_WIDTH+4 for CIM.
- Simultaneous busy fall and timeout at the same edge: normal completion wins (rsp_err=0).

Test Plan:
- Read addr=5: controller model gives rd_data_enable with macro_rd_data=0xA5 → rsp_valid at E0+4, rsp_data=0x00A5, rsp_err=0; exactly one ctrl_start pulse with ctrl_r_w_cim=01.
- Write addr=3 wdata=0x3C → macro_addr=3, macro_wdata=0x3C held through RUN; response at E0+4 with rsp_data=0, rsp_err=0.
- CIM operand=8'b1011_0010, macro_cim_data=0x1234 → cim_in_bit sequence 1,0,1,1,0,0,1,0 starting at the in_msb slot; rsp_data=0x1234 at E0+12.
- cmd_op=00 → no ctrl_start; rsp_err=1 one cycle after accept. Then hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_data stay stable and cmd_ready stays 0.
- Controller busy stuck high after CIM start → rsp_err=1, rsp_data=0 after 64 cycles. Busy never rising → rsp_err=1 after 4 WAIT_BUSY cycles.
- Assert rst_n low mid-CIM (RUN) → all outputs 0 immediately. After release, cmd_ready=1 and a new read completes normally.
